// File: rtl/apb_mem_slave_pkg.sv
// apb_mem_slave_pkg
//   Shared definitions for the APB memory slave: bus widths, transfer-size
//   (strobe) encodings, FSM state constants, default address limit and a
//   helper that builds the read-data mask for a transfer size.
package apb_mem_slave_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned MEM_DEPTH   = 4;   // byte lanes per memory word
  localparam int unsigned STRB_SIZE   = 2;
  localparam int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_WIDTH   = $clog2(16);

  localparam int unsigned DEFAULT_ADDR_LIMIT = 1024;

  localparam logic [STRB_SIZE-1:0] STRB_BYTE = 2'd0;
  localparam logic [STRB_SIZE-1:0] STRB_HALF = 2'd1;
  localparam logic [STRB_SIZE-1:0] STRB_WORD = 2'd2;
  localparam logic [STRB_SIZE-1:0] STRB_RSVD = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_RWAIT = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [STRB_SIZE-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    case (strb)
      STRB_BYTE: m = 32'h0000_00FF;
      STRB_HALF: m = 32'h0000_FFFF;
      default:   m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/apb_mem_slave_decode.sv
// apb_slv_decode
//   Combinational transfer decode.
//   strobe     : transfer size (byte / half / word / reserved)
//   addr       : byte address of the transfer
//   mem_be     : byte-lane enables for the addressed word
//   lane_shift : bit shift aligning LSB-justified data to its lane (8*addr[1:0])
//   error      : reserved size, misaligned half/word, or address out of range
module apb_slv_decode
  import apb_mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
  input  logic [STRB_SIZE-1:0]   strobe,
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic [MEM_DEPTH-1:0]   mem_be,
  output logic [SHIFT_WIDTH-1:0] lane_shift,
  output logic                   error
);

  always_comb begin
    mem_be     = '0;
    error      = 1'b0;
    lane_shift = {addr[1:0], 3'b000};
    case (strobe)
      STRB_BYTE: mem_be = 4'b0001 << addr[1:0];
      STRB_HALF: begin
        mem_be = 4'b0011 << addr[1:0];
        error  = addr[0];
      end
      STRB_WORD: begin
        mem_be = 4'b1111;
        error  = (addr[1:0] != 2'b00);
      end
      default:   error = 1'b1;
    endcase
    if (addr >= ADDR_WIDTH'(ADDR_LIMIT)) error = 1'b1;
  end

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
//   APB slave bridging single transfers onto a simple synchronous memory.
//   clk, rst_n          : clock, asynchronous active-low reset
//   sel, enable, write  : APB control (setup = sel & !enable)
//   strobe, addr, wdata : transfer size, byte address, LSB-justified data
//   ready, slverr       : one-cycle completion strobe and error flag
//   rdata               : LSB-justified read data, held between transfers
//   mem_wr, mem_rd      : one-cycle memory strobes
//   mem_be, mem_address : byte lanes and word-aligned address
//   mem_data_in         : lane-aligned write data
//   mem_data_out        : memory read word, RD_LAT cycles after mem_rd
module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [STRB_SIZE-1:0]  strobe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  slverr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [MEM_DEPTH-1:0]  mem_be,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  logic [2:0]              state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [ADDR_WIDTH-3:0]   word_addr_q;
  logic [MEM_DEPTH-1:0]    be_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic [STRB_SIZE-1:0]    size_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [MEM_DEPTH-1:0]    dec_be;
  logic [SHIFT_WIDTH-1:0]  dec_shift;
  logic                    dec_err;
  logic                    setup;
  logic                    mem_access;
  logic [DATA_WIDTH-1:0]   rd_extract;

  apb_slv_decode #(
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_decode (
    .strobe     (strobe),
    .addr       (addr),
    .mem_be     (dec_be),
    .lane_shift (dec_shift),
    .error      (dec_err)
  );

  assign setup      = sel && !enable;
  assign rd_extract = (mem_data_out >> shift_q) & size_mask(size_q);

  // cnt tracks cycles elapsed since the mem_rd cycle; the memory word is
  // sampled once it reaches RD_LAT-1 (RD itself when RD_LAT is 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      word_addr_q <= '0;
      be_q        <= '0;
      data_q      <= '0;
      shift_q     <= '0;
      size_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            word_addr_q <= addr[ADDR_WIDTH-1:2];
            be_q        <= dec_be;
            data_q      <= wdata << dec_shift;
            shift_q     <= dec_shift;
            size_q      <= strobe;
            err_q       <= dec_err;
            if (dec_err) begin
              rdata_q <= '0;
              state   <= ST_RESP;
            end else if (write) begin
              state <= ST_WR;
            end else begin
              cnt   <= '0;
              state <= ST_RD;
            end
          end
        end
        ST_WR: state <= sel ? ST_RESP : ST_IDLE;
        ST_RD: begin
          if (!sel) begin
            state <= ST_IDLE;
          end else if (RD_LAT <= 1) begin
            rdata_q <= rd_extract;
            state   <= ST_RESP;
          end else begin
            cnt   <= CNT_WIDTH'(1);
            state <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (!sel) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_WIDTH'(RD_LAT - 1)) begin
            rdata_q <= rd_extract;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_access  = (state == ST_WR) || (state == ST_RD);
  assign ready       = (state == ST_RESP);
  assign slverr      = ready && err_q;
  assign rdata       = rdata_q;
  assign mem_wr      = (state == ST_WR);
  assign mem_rd      = (state == ST_RD);
  assign mem_be      = mem_access ? be_q : '0;
  assign mem_address = mem_access ? {word_addr_q, 2'b00} : '0;
  assign mem_data_in = mem_access ? data_q : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, enable, write;
  logic [1:0]  strobe;
  logic [31:0] addr, wdata, mem_data_out;

  logic        d1_ready, d1_slverr, d1_mem_wr, d1_mem_rd;
  logic [31:0] d1_rdata, d1_mem_address, d1_mem_data_in;
  logic [3:0]  d1_mem_be;
  logic        d3_ready, d3_slverr, d3_mem_wr, d3_mem_rd;
  logic [31:0] d3_rdata, d3_mem_address, d3_mem_data_in;
  logic [3:0]  d3_mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_mem_slave #(.RD_LAT(1), .ADDR_LIMIT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .enable(enable), .write(write),
    .strobe(strobe), .addr(addr), .wdata(wdata),
    .ready(d1_ready), .slverr(d1_slverr), .rdata(d1_rdata),
    .mem_wr(d1_mem_wr), .mem_rd(d1_mem_rd), .mem_be(d1_mem_be),
    .mem_address(d1_mem_address), .mem_data_in(d1_mem_data_in),
    .mem_data_out(mem_data_out)
  );

  apb_mem_slave #(.RD_LAT(3), .ADDR_LIMIT(1024)) dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .enable(enable), .write(write),
    .strobe(strobe), .addr(addr), .wdata(wdata),
    .ready(d3_ready), .slverr(d3_slverr), .rdata(d3_rdata),
    .mem_wr(d3_mem_wr), .mem_rd(d3_mem_rd), .mem_be(d3_mem_be),
    .mem_address(d3_mem_address), .mem_data_in(d3_mem_data_in),
    .mem_data_out(mem_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_setup(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; enable = 1'b0; write = w; strobe = s; addr = a; wdata = d;
  endtask

  task automatic do_access();
    enable = 1'b1;
  endtask

  task automatic do_idle();
    sel = 1'b0; enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; enable = 1'b0; write = 1'b0;
    strobe = 2'd0; addr = '0; wdata = '0; mem_data_out = '0;
    tick(); tick();

    // reset state
    check("rst_ready",   {31'b0, d1_ready},  32'h0);
    check("rst_slverr",  {31'b0, d1_slverr}, 32'h0);
    check("rst_mem_wr",  {31'b0, d1_mem_wr}, 32'h0);
    check("rst_mem_rd",  {31'b0, d1_mem_rd}, 32'h0);
    check("rst_mem_be",  {28'b0, d1_mem_be}, 32'h0);
    check("rst_mem_adr", d1_mem_address,     32'h0);
    check("rst_mem_din", d1_mem_data_in,     32'h0);
    check("rst_rdata",   d1_rdata,           32'h0);
    rst_n = 1'b1;
    tick();

    // word write 0x10
    do_setup(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    tick();
    check("ww_mem_wr",  {31'b0, d1_mem_wr}, 32'h1);
    check("ww_mem_be",  {28'b0, d1_mem_be}, 32'hF);
    check("ww_mem_adr", d1_mem_address,     32'h10);
    check("ww_mem_din", d1_mem_data_in,     32'hDEADBEEF);
    check("ww_t1_ready",{31'b0, d1_ready},  32'h0);
    do_access();
    tick();
    check("ww_t2_mem_wr", {31'b0, d1_mem_wr}, 32'h0);
    check("ww_ready",     {31'b0, d1_ready},  32'h1);
    check("ww_slverr",    {31'b0, d1_slverr}, 32'h0);
    do_idle();
    tick();
    check("ww_ready_once", {31'b0, d1_ready}, 32'h0);

    // half write 0x22
    do_setup(1'b1, 2'd1, 32'h22, 32'h0000A5A5);
    tick();
    check("hw_mem_be",  {28'b0, d1_mem_be}, 32'hC);
    check("hw_mem_din", d1_mem_data_in,     32'hA5A50000);
    check("hw_mem_adr", d1_mem_address,     32'h20);
    do_access();
    tick();
    check("hw_ready", {31'b0, d1_ready}, 32'h1);
    do_idle();
    tick();

    // byte read 0x13, memory word 0x11223344
    mem_data_out = 32'h11223344;
    do_setup(1'b0, 2'd0, 32'h13, 32'h0);
    tick();
    check("br_mem_rd", {31'b0, d1_mem_rd}, 32'h1);
    check("br_mem_wr", {31'b0, d1_mem_wr}, 32'h0);
    check("br_mem_be", {28'b0, d1_mem_be}, 32'h8);
    check("br_t1_ready", {31'b0, d1_ready}, 32'h0);
    do_access();
    tick();
    check("br_ready",  {31'b0, d1_ready},  32'h1);
    check("br_slverr", {31'b0, d1_slverr}, 32'h0);
    check("br_rdata",  d1_rdata,           32'h00000011);
    do_idle();
    tick();
    check("br_rdata_hold", d1_rdata, 32'h00000011);

    // half read 0x12
    do_setup(1'b0, 2'd1, 32'h12, 32'h0);
    tick(); do_access(); tick();
    check("hr_rdata", d1_rdata, 32'h00001122);
    do_idle(); tick();

    // word read 0x0
    do_setup(1'b0, 2'd2, 32'h0, 32'h0);
    tick(); do_access(); tick();
    check("wr0_rdata", d1_rdata, 32'h11223344);
    do_idle(); tick();

    // misaligned word read 0x02
    do_setup(1'b0, 2'd2, 32'h02, 32'h0);
    tick();
    check("e02_ready",  {31'b0, d1_ready},  32'h1);
    check("e02_slverr", {31'b0, d1_slverr}, 32'h1);
    check("e02_rdata",  d1_rdata,           32'h0);
    check("e02_mem_rd", {31'b0, d1_mem_rd}, 32'h0);
    do_access();
    tick();
    check("e02_ready_once", {31'b0, d1_ready},  32'h0);
    check("e02_no_mem_rd",  {31'b0, d1_mem_rd}, 32'h0);
    do_idle(); tick();

    // out-of-range word write 0x400
    do_setup(1'b1, 2'd2, 32'h400, 32'h1);
    tick();
    check("e400_ready",  {31'b0, d1_ready},  32'h1);
    check("e400_slverr", {31'b0, d1_slverr}, 32'h1);
    check("e400_mem_wr", {31'b0, d1_mem_wr}, 32'h0);
    do_idle(); tick();
    check("e400_no_mem_wr", {31'b0, d1_mem_wr}, 32'h0);

    // reserved size, misaligned half
    do_setup(1'b0, 2'd3, 32'h0, 32'h0);
    tick();
    check("ersv_slverr", {31'b0, d1_slverr}, 32'h1);
    do_idle(); tick();
    do_setup(1'b1, 2'd1, 32'h5, 32'h0);
    tick();
    check("eh5_slverr", {31'b0, d1_slverr}, 32'h1);
    check("eh5_mem_wr", {31'b0, d1_mem_wr}, 32'h0);
    do_idle(); tick();

    // last legal byte 0x3FF
    do_setup(1'b1, 2'd0, 32'h3FF, 32'hAB);
    tick();
    check("b3ff_mem_wr",  {31'b0, d1_mem_wr}, 32'h1);
    check("b3ff_mem_be",  {28'b0, d1_mem_be}, 32'h8);
    check("b3ff_mem_din", d1_mem_data_in,     32'hAB000000);
    check("b3ff_mem_adr", d1_mem_address,     32'h3FC);
    do_access(); tick();
    check("b3ff_slverr", {31'b0, d1_slverr}, 32'h0);
    do_idle(); tick();

    // access phase without setup is ignored
    sel = 1'b1; enable = 1'b1; write = 1'b1; strobe = 2'd2; addr = 32'h10;
    tick();
    check("noset_mem_wr", {31'b0, d1_mem_wr}, 32'h0);
    tick();
    check("noset_ready",  {31'b0, d1_ready},  32'h0);
    do_idle(); tick();

    // RD_LAT=3 word read 0x8
    mem_data_out = 32'hFFFFFFFF;
    do_setup(1'b0, 2'd2, 32'h8, 32'h0);
    tick();
    check("l3_mem_rd", {31'b0, d3_mem_rd}, 32'h1);
    do_access();
    tick();
    check("l3_t2_mem_rd", {31'b0, d3_mem_rd}, 32'h0);
    check("l3_t2_ready",  {31'b0, d3_ready},  32'h0);
    tick();
    check("l3_t3_ready",  {31'b0, d3_ready},  32'h0);
    mem_data_out = 32'hCAFEF00D;
    tick();
    check("l3_ready", {31'b0, d3_ready}, 32'h1);
    check("l3_rdata", d3_rdata,          32'hCAFEF00D);
    mem_data_out = '0;
    do_idle(); tick();

    // reset pulse while waiting on RD_LAT=3 read
    do_setup(1'b0, 2'd2, 32'h4, 32'h0);
    tick(); do_access(); tick();
    rst_n = 1'b0;
    #1;
    check("rw_rst_rdata",  d3_rdata,           32'h0);
    check("rw_rst_ready",  {31'b0, d3_ready},  32'h0);
    check("rw_rst_mem_rd", {31'b0, d3_mem_rd}, 32'h0);
    do_idle();
    tick();
    check("rw_rst_hold_ready", {31'b0, d3_ready}, 32'h0);
    rst_n = 1'b1;
    tick();
    do_setup(1'b1, 2'd2, 32'h30, 32'h12345678);
    tick();
    check("rw_post_mem_wr",  {31'b0, d3_mem_wr}, 32'h1);
    check("rw_post_mem_adr", d3_mem_address,     32'h30);
    check("rw_post_mem_din", d3_mem_data_in,     32'h12345678);
    do_access(); tick();
    check("rw_post_ready",  {31'b0, d3_ready},  32'h1);
    check("rw_post_slverr", {31'b0, d3_slverr}, 32'h0);
    do_idle(); tick();

    // back-to-back write then read, read aborted by sel drop in RD
    do_setup(1'b1, 2'd2, 32'h40, 32'h55AA55AA);
    tick();
    check("bb_mem_wr", {31'b0, d1_mem_wr}, 32'h1);
    do_access(); tick();
    check("bb_w_ready", {31'b0, d1_ready}, 32'h1);
    do_setup(1'b0, 2'd2, 32'h40, 32'h0);
    tick();
    check("bb_idle_ready", {31'b0, d1_ready},  32'h0);
    check("bb_idle_mem_rd",{31'b0, d1_mem_rd}, 32'h0);
    tick();
    check("bb_mem_rd", {31'b0, d1_mem_rd}, 32'h1);
    do_idle();
    tick();
    check("bb_abort_ready",  {31'b0, d1_ready},  32'h0);
    check("bb_abort_mem_rd", {31'b0, d1_mem_rd}, 32'h0);
    tick();
    check("bb_abort_ready2", {31'b0, d1_ready},  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
